dma_arbiter: RTL and testbench
==============================

Name: dma_arbiter

Overview:
- Shares the single DCPU memory DMA port (DMA_addr/DMA_data/DMA_wren/DMA_q) among N device requesters: monitor VRAM refresh, font/palette loaders, future floppy.
- Round-robin arbitration with bounded bursts, so the monitor's 384-word refresh cannot starve other devices and vice versa.
- Sits between the devices and the DCPU memory's DMA port, clocked by DMA_CLOCK.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- MAX_BURST, 16, maximum accesses per grant before forced re-arbitration (1..256)
- ADDR_W, 16, DMA address/data width

Ports:
- DMA_CLOCK  in  1  DMA clock; all state updates on rising edge
- RESET  in  1  asynchronous, active-high reset
- req  in  N_REQ  per-requester request; held high while it wants accesses
- last  in  N_REQ  marks the current access as the final one of the burst
- wr_en  in  N_REQ  per-requester write enable for the current access
- addr_in  in  N_REQ*16  per-requester address, slice i = [16i+15:16i]
- wdata_in  in  N_REQ*16  per-requester write data
- grant  out  N_REQ  one-hot registered grant; all zeros when idle
- issue  out  N_REQ  one-hot: access of requester i is presented to memory this cycle
- rd_valid  out  N_REQ  one-hot: rd_data holds the read result for requester i
- rd_data  out  16  registered copy of DMA_q, broadcast to all requesters
- DMA_addr  out  16  memory address
- DMA_data  out  16  memory write data
- DMA_wren  out  1  memory write strobe
- DMA_q  in  16  memory read data, valid one cycle after the address is presented

Behaviour:
- Reset (async): state=IDLE; grant=0, issue=0, rd_valid=0, rd_data=0; rr_ptr=0; burst_cnt=0. DMA_addr=0, DMA_data=0, DMA_wren=0 while no grant.
- FSM, 2 states:
  - IDLE: if any req, pick winner = first set req at index ≥ rr_ptr, wrapping modulo N_REQ. Register grant=onehot(winner), burst_cnt=0, go to BURST. No access is issued in IDLE.
  - BURST: with g = granted index, issue[g] = req[g]. While issue[g], DMA_addr/DMA_data/DMA_wren come combinationally from slice g of addr_in/wdata_in/wr_en. When no access is issued, DMA_wren=0 and DMA_addr/DMA_data hold 0.
- Burst end: any of
  - req[g]=0: no access that cycle
  - issue[g] with last[g]=1: that access is performed
  - issue[g] when burst_cnt == MAX_BURST-1: that access is performed
- On burst end, the next edge sets grant=0, state=IDLE, rr_ptr=(g+1) mod N_REQ.
  - Every grant is followed by at least one IDLE gap cycle.
  - Grant latency from req to grant is 1 cycle when idle.
- burst_cnt increments per issued access. Width is clog2(MAX_BURST)+1 and it never wraps.
- Read return: one edge after an issued read (wr_en=0) by requester i, rd_valid[i]=1 for one cycle and rd_data = DMA_q sampled at that edge. Writes produce no rd_valid.
  - The return occurs even if the grant has already dropped (IDLE gap cycle).
  - Requesters must accept rd_valid at any time.
- Simultaneous requests: only the rotating priority decides; a requester raising req during another's burst waits.
- req of a non-granted requester has no effect on the memory port.
- Reset mid-burst: everything clears immediately. A read issued in the reset cycle never returns rd_valid.
- Exactly one bit of issue and of rd_valid set, or none. DMA_wren is never high without issue.

Decomposition:
- Package dma_pkg:
  - state enum dma_state_t {DMA_IDLE, DMA_BURST}
  - constant DMA_ADDR_W=16
  - function onehot() used for grant generation
- One sub-module: rr_priority_pick. Combinational rotating-priority encoder with inputs req vector and rr_ptr, outputs winner index and any_req.

Test Plan:
- Single read burst: req[0]=1 with addrs F000..F003, last on the 4th access. Required: grant[0] one cycle later; DMA_addr F000..F003 on 4 consecutive cycles; rd_valid[0] with memory contents one cycle after each; grant=0 after the 4th access.
- Round-robin fairness: req[0] and req[2] held continuously, MAX_BURST=16. Required: grant alternates 0,2,0,2; each burst is exactly 16 accesses; 1 idle gap cycle between bursts.
- Write path: req[1], wr_en=1, addr 0x0100, data 0xBEEF, last=1. Required: DMA_wren=1 for exactly one cycle with that address/data; rd_valid stays 0; a later read of 0x0100 returns 0xBEEF.
- Early release: req[3] drops after 5 accesses, no last. Required: exactly 5 issues; grant drops the following edge; rr_ptr=0 so a waiting req[0] wins next.
- Async reset mid-burst: assert RESET between edges during a read burst. Required: grant, issue, rd_valid, DMA_wren go 0 immediately; no rd_valid appears after release; first grant after reset goes to the lowest active requester ≥0.
- Pointer wrap: N_REQ=4, last winner 3, req[1] and req[3] pending. Required: requester 1 wins next.

Source files
------------

// File: rtl/dma_pkg.sv
// ---------------------------------------------------------------------------
// dma_pkg
// Shared types and helpers for the DMA port arbiter.
//   dma_state_t : arbiter FSM states (idle gap / burst in progress)
//   DMA_ADDR_W  : width of the DCPU memory DMA address and data buses
//   DMA_MAX_REQ : largest supported requester count
//   onehot()    : converts a requester index into a one-hot grant vector
// ---------------------------------------------------------------------------
package dma_pkg;

  typedef enum logic {
    DMA_IDLE,
    DMA_BURST
  } dma_state_t;

  localparam int DMA_ADDR_W  = 16;
  localparam int DMA_MAX_REQ = 8;

  // Result is as wide as the largest arbiter; callers truncate to N_REQ bits.
  function automatic logic [DMA_MAX_REQ-1:0] onehot(input logic [2:0] idx);
    logic [DMA_MAX_REQ-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/dma_arbiter_rr_priority_pick.sv
// ---------------------------------------------------------------------------
// rr_priority_pick
// Combinational rotating-priority encoder. Searches req_i starting at
// rr_ptr_i and wrapping modulo N_REQ; reports the first set index.
//   req_i     : request vector
//   rr_ptr_i  : index with the highest priority this round
//   winner_o  : index of the first set request at or after rr_ptr_i
//   any_req_o : at least one request bit is set
// ---------------------------------------------------------------------------
module rr_priority_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PTR_W-1:0] rr_ptr_i,
  output logic [PTR_W-1:0] winner_o,
  output logic             any_req_o
);

  int idx;

  // Scan from the lowest priority to the highest so the final hit is the
  // requester closest to the pointer.
  always_comb begin
    winner_o  = '0;
    any_req_o = 1'b0;
    idx       = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr_i) + k) % N_REQ;
      if (req_i[idx[PTR_W-1:0]]) begin
        winner_o  = idx[PTR_W-1:0];
        any_req_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_arbiter.sv
// ---------------------------------------------------------------------------
// dma_arbiter
// Shares the single DCPU memory DMA port among N_REQ device requesters with
// round-robin arbitration and bursts capped at MAX_BURST accesses.
// Ports:
//   DMA_CLOCK, RESET           : clock, async active-high reset
//   req/last/wr_en             : per-requester request, end-of-burst mark,
//                                write enable
//   addr_in/wdata_in           : per-requester address/data, ADDR_W per slice
//   grant                      : registered one-hot grant (0 when idle)
//   issue                      : one-hot, access presented to memory now
//   rd_valid/rd_data           : registered read return, one edge after issue
//   DMA_addr/DMA_data/DMA_wren : memory port driven from the granted slice
//   DMA_q                      : memory read data, valid at the edge that
//                                follows address presentation
// ---------------------------------------------------------------------------
module dma_arbiter
  import dma_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 16,
  parameter int ADDR_W    = DMA_ADDR_W
) (
  input  logic                    DMA_CLOCK,
  input  logic                    RESET,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        last,
  input  logic [N_REQ-1:0]        wr_en,
  input  logic [N_REQ*ADDR_W-1:0] addr_in,
  input  logic [N_REQ*ADDR_W-1:0] wdata_in,
  output logic [N_REQ-1:0]        grant,
  output logic [N_REQ-1:0]        issue,
  output logic [N_REQ-1:0]        rd_valid,
  output logic [ADDR_W-1:0]       rd_data,
  output logic [ADDR_W-1:0]       DMA_addr,
  output logic [ADDR_W-1:0]       DMA_data,
  output logic                    DMA_wren,
  input  logic [ADDR_W-1:0]       DMA_q
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  dma_state_t         state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [PTR_W-1:0]   gidx_q, gidx_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic [N_REQ-1:0]   rd_valid_q, rd_valid_d;
  logic [ADDR_W-1:0]  rd_data_q, rd_data_d;

  logic [PTR_W-1:0]   winner;
  logic               any_req;
  logic               cur_req;
  logic               burst_end;

  rr_priority_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req_i     (req),
    .rr_ptr_i  (rr_ptr_q),
    .winner_o  (winner),
    .any_req_o (any_req)
  );

  // The granted index is kept alongside the one-hot grant so the memory port
  // mux can select the slice directly.
  always_ff @(posedge DMA_CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q     <= DMA_IDLE;
      grant_q     <= '0;
      gidx_q      <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      rd_valid_q  <= '0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    rd_valid_d  = '0;
    rd_data_d   = rd_data_q;
    issue       = '0;
    DMA_addr    = '0;
    DMA_data    = '0;
    DMA_wren    = 1'b0;
    cur_req     = req[gidx_q];
    burst_end   = 1'b0;

    unique case (state_q)
      DMA_IDLE: begin
        if (any_req) begin
          state_d     = DMA_BURST;
          grant_d     = N_REQ'(onehot(3'(winner)));
          gidx_d      = winner;
          burst_cnt_d = '0;
        end
      end

      DMA_BURST: begin
        if (cur_req) begin
          issue       = grant_q;
          DMA_addr    = addr_in[int'(gidx_q)*ADDR_W +: ADDR_W];
          DMA_data    = wdata_in[int'(gidx_q)*ADDR_W +: ADDR_W];
          DMA_wren    = wr_en[gidx_q];
          burst_cnt_d = burst_cnt_q + 1'b1;
          if (!wr_en[gidx_q]) begin
            rd_valid_d = grant_q;
            rd_data_d  = DMA_q;
          end
        end
        // A dropped request, a marked last access, or the burst cap all end
        // the grant; the access in that cycle (if any) still completes.
        burst_end = !cur_req || last[gidx_q] ||
                    (burst_cnt_q == CNT_W'(MAX_BURST - 1));
        if (burst_end) begin
          state_d  = DMA_IDLE;
          grant_d  = '0;
          rr_ptr_d = (gidx_q == PTR_W'(N_REQ - 1)) ? '0 : gidx_q + 1'b1;
        end
      end

      default: begin
        state_d = DMA_IDLE;
        grant_d = '0;
      end
    endcase
  end

  assign grant    = grant_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_dma_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dma_arbiter
// Requester drivers feed queued accesses into the arbiter; a cycle-level
// reference model of the arbitration rules predicts grant, memory port and
// read-return behaviour into scoreboard queues that a monitor checks.
// ---------------------------------------------------------------------------
module tb_dma_arbiter;

  localparam int N  = 4;
  localparam int MB = 16;
  localparam int AW = 16;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
    logic        wr;
    logic        lst;
    int          gap;
  } acc_t;

  typedef struct packed {
    logic [N-1:0] grant;
    logic [N-1:0] issue;
    logic [N-1:0] rdValid;
    logic         wren;
    logic [15:0]  addr;
    logic [15:0]  data;
  } exp_t;

  logic              DMA_CLOCK = 1'b0;
  logic              RESET     = 1'b1;
  logic [N-1:0]      req       = '0;
  logic [N-1:0]      last      = '0;
  logic [N-1:0]      wr_en     = '0;
  logic [N*AW-1:0]   addr_in   = '0;
  logic [N*AW-1:0]   wdata_in  = '0;
  logic [N-1:0]      grant, issue, rd_valid;
  logic [AW-1:0]     rd_data, DMA_addr, DMA_data, DMA_q;
  logic              DMA_wren;

  logic [15:0]       ram  [0:65535];
  logic [15:0]       mMem [0:65535];

  acc_t              accQ [N][$];
  int                waitCnt [N];
  logic [N-1:0]      issuedPrev = '0;

  exp_t              expQ [$];
  logic [15:0]       rdQ [N][$];

  int compared   = 0;
  int mismatched = 0;

  int mBusy   = 0;
  int mG      = 0;
  int mCnt    = 0;
  int mPtr    = 0;
  int mRdPend = -1;

  dma_arbiter #(
    .N_REQ     (N),
    .MAX_BURST (MB),
    .ADDR_W    (AW)
  ) dut (
    .DMA_CLOCK (DMA_CLOCK),
    .RESET     (RESET),
    .req       (req),
    .last      (last),
    .wr_en     (wr_en),
    .addr_in   (addr_in),
    .wdata_in  (wdata_in),
    .grant     (grant),
    .issue     (issue),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .DMA_addr  (DMA_addr),
    .DMA_data  (DMA_data),
    .DMA_wren  (DMA_wren),
    .DMA_q     (DMA_q)
  );

  always #5 DMA_CLOCK = ~DMA_CLOCK;

  // Memory behind the DMA port: read data settles within the address cycle
  // and is captured by the arbiter at the following edge.
  assign DMA_q = ram[DMA_addr];

  always @(posedge DMA_CLOCK) begin
    if (DMA_wren) ram[DMA_addr] <= DMA_data;
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic failNow(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: timed out at %0t", name, $time);
  endtask

  task automatic applyStimulus(input int i, input logic [15:0] a,
                               input logic [15:0] d, input logic wr,
                               input logic lst, input int gap);
    acc_t x;
    x.addr = a;
    x.data = d;
    x.wr   = wr;
    x.lst  = lst;
    x.gap  = gap;
    if (accQ[i].size() == 0) waitCnt[i] = gap;
    accQ[i].push_back(x);
  endtask

  // Requester drivers: each holds req while it has queued work, advancing
  // to the next access whenever its previous one was issued.
  always @(posedge DMA_CLOCK) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (issuedPrev[i] && accQ[i].size() > 0) begin
        void'(accQ[i].pop_front());
        if (accQ[i].size() > 0) waitCnt[i] = accQ[i][0].gap;
      end
      if (waitCnt[i] > 0) begin
        req[i] = 1'b0;
        waitCnt[i]--;
      end else begin
        req[i] = (accQ[i].size() > 0);
      end
      if (accQ[i].size() > 0) begin
        addr_in[i*AW +: AW]  = accQ[i][0].addr;
        wdata_in[i*AW +: AW] = accQ[i][0].data;
        wr_en[i]             = accQ[i][0].wr;
        last[i]              = accQ[i][0].lst;
      end else begin
        addr_in[i*AW +: AW]  = 16'($urandom);
        wdata_in[i*AW +: AW] = 16'($urandom);
        wr_en[i]             = 1'($urandom);
        last[i]              = 1'($urandom);
      end
    end
  end

  always @(negedge DMA_CLOCK) issuedPrev = issue;

  // Reference model: tracks which requester owns the port, how many
  // accesses it has made, and where the rotating search starts next.
  always @(posedge DMA_CLOCK) begin
    exp_t        e;
    logic [15:0] a;
    logic [15:0] d;
    int          done;
    #2;
    e = '0;
    if (RESET) begin
      mBusy   = 0;
      mPtr    = 0;
      mCnt    = 0;
      mRdPend = -1;
      for (int i = 0; i < N; i++) rdQ[i].delete();
    end else begin
      if (mRdPend >= 0) e.rdValid[mRdPend] = 1'b1;
      mRdPend = -1;
      if (mBusy != 0) begin
        e.grant[mG] = 1'b1;
        if (req[mG]) begin
          a = addr_in[mG*AW +: AW];
          d = wdata_in[mG*AW +: AW];
          e.issue[mG] = 1'b1;
          e.addr      = a;
          e.data      = d;
          e.wren      = wr_en[mG];
          if (wr_en[mG]) mMem[a] = d;
          else begin
            rdQ[mG].push_back(mMem[a]);
            mRdPend = mG;
          end
          mCnt++;
          done = (last[mG] || mCnt == MB) ? 1 : 0;
        end else begin
          done = 1;
        end
        if (done != 0) begin
          mBusy = 0;
          mPtr  = (mG + 1) % N;
        end
      end else if (req != '0) begin
        for (int k = N - 1; k >= 0; k--) begin
          if (req[(mPtr + k) % N]) mG = (mPtr + k) % N;
        end
        mBusy = 1;
        mCnt  = 0;
      end
    end
    expQ.push_back(e);
  end

  // Monitor: compares each cycle's DUT outputs against the prediction and
  // matches every read return to the queued expected data of its requester.
  always @(negedge DMA_CLOCK) begin
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("grant", 32'(grant), 32'(e.grant));
      checkOutput("issue", 32'(issue), 32'(e.issue));
      checkOutput("DMA_wren", 32'(DMA_wren), 32'(e.wren));
      checkOutput("rd_valid", 32'(rd_valid), 32'(e.rdValid));
      if (e.issue != '0) begin
        checkOutput("DMA_addr", 32'(DMA_addr), 32'(e.addr));
        if (e.wren) checkOutput("DMA_data", 32'(DMA_data), 32'(e.data));
      end else begin
        checkOutput("DMA_addr_idle", 32'(DMA_addr), 32'h0);
      end
      for (int i = 0; i < N; i++) begin
        if (rd_valid[i]) begin
          if (rdQ[i].size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL rd_unexpected: requester %0d got rd_valid, expected none", i);
          end else begin
            checkOutput("rd_data", 32'(rd_data), 32'(rdQ[i].pop_front()));
          end
        end
      end
    end
  end

  task automatic drain();
    int c;
    int busy;
    c = 0;
    busy = 1;
    while (busy != 0 && c < 2000) begin
      @(posedge DMA_CLOCK);
      #3;
      busy = (grant != '0 || issue != '0) ? 1 : 0;
      for (int i = 0; i < N; i++) if (accQ[i].size() > 0) busy = 1;
      c++;
    end
    if (busy != 0) failNow("drain");
    repeat (3) @(posedge DMA_CLOCK);
    #3;
  endtask

  task automatic waitGrant(input int i);
    int c;
    c = 0;
    while (!grant[i] && c < 200) begin
      @(posedge DMA_CLOCK);
      #3;
      c++;
    end
    if (!grant[i]) failNow("wait_grant");
  endtask

  initial begin
    int len;
    int ri;
    for (int a = 0; a < 65536; a++) begin
      ram[a]  = 16'(a) ^ 16'h5A5A;
      mMem[a] = 16'(a) ^ 16'h5A5A;
    end
    for (int i = 0; i < N; i++) waitCnt[i] = 0;

    repeat (3) @(posedge DMA_CLOCK);
    #3;
    checkOutput("reset_grant", 32'(grant), 32'h0);
    checkOutput("reset_rd_data", 32'(rd_data), 32'h0);
    checkOutput("reset_wren", 32'(DMA_wren), 32'h0);
    @(posedge DMA_CLOCK);
    #1 RESET = 1'b0;
    #2;

    $display("[TB] single read burst");
    for (int k = 0; k < 4; k++) applyStimulus(0, 16'hF000 + 16'(k), 16'h0, 1'b0, k == 3, 0);
    drain();

    $display("[TB] round-robin fairness");
    for (int k = 0; k < 40; k++) begin
      applyStimulus(0, 16'($urandom_range(0, 63)), 16'h0, 1'b0, 1'b0, 0);
      applyStimulus(2, 16'($urandom_range(0, 63)), 16'h0, 1'b0, 1'b0, 0);
    end
    drain();

    $display("[TB] write path");
    applyStimulus(1, 16'h0100, 16'hBEEF, 1'b1, 1'b1, 0);
    drain();
    checkOutput("mem_written", 32'(ram[16'h0100]), 32'h0000BEEF);
    applyStimulus(1, 16'h0100, 16'h0, 1'b0, 1'b1, 0);
    drain();

    $display("[TB] early release");
    for (int k = 0; k < 5; k++) applyStimulus(3, 16'h0200 + 16'(k), 16'h0, 1'b0, 1'b0, 0);
    applyStimulus(0, 16'h0300, 16'h0, 1'b0, 1'b1, 2);
    drain();

    $display("[TB] reset mid-burst");
    for (int k = 0; k < 10; k++) applyStimulus(0, 16'h0400 + 16'(k), 16'h0, 1'b0, 1'b0, 0);
    waitGrant(0);
    repeat (2) @(posedge DMA_CLOCK);
    #6 RESET = 1'b1;
    #1;
    checkOutput("rst_grant", 32'(grant), 32'h0);
    checkOutput("rst_issue", 32'(issue), 32'h0);
    checkOutput("rst_rd_valid", 32'(rd_valid), 32'h0);
    checkOutput("rst_wren", 32'(DMA_wren), 32'h0);
    for (int i = 0; i < N; i++) begin
      accQ[i].delete();
      waitCnt[i] = 0;
    end
    applyStimulus(2, 16'h0500, 16'h0, 1'b0, 1'b1, 0);
    applyStimulus(1, 16'h0501, 16'h0, 1'b0, 1'b1, 0);
    repeat (2) @(posedge DMA_CLOCK);
    #1 RESET = 1'b0;
    drain();

    $display("[TB] pointer wrap");
    applyStimulus(3, 16'h0600, 16'h0, 1'b0, 1'b1, 0);
    waitGrant(3);
    applyStimulus(1, 16'h0601, 16'h0, 1'b0, 1'b1, 0);
    applyStimulus(3, 16'h0602, 16'h0, 1'b0, 1'b1, 0);
    drain();

    $display("[TB] random traffic");
    for (int b = 0; b < 60; b++) begin
      ri  = $urandom_range(0, N - 1);
      len = $urandom_range(1, 20);
      for (int k = 0; k < len; k++) begin
        applyStimulus(ri, 16'($urandom_range(0, 31)), 16'($urandom),
                      ($urandom_range(0, 2) == 0), (k == len - 1) && ($urandom_range(0, 1) == 1),
                      (k == 0) ? $urandom_range(0, 3) : 0);
      end
      repeat ($urandom_range(0, 8)) @(posedge DMA_CLOCK);
      #3;
    end
    drain();

    for (int i = 0; i < N; i++) checkOutput("rd_queue_empty", 32'(rdQ[i].size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
